// File: rtl/fofb_trn_rx_req_decoder.sv
// fofb_trn_rx_req_decoder: TRN RX target engine turning single-DW MWr/MRd TLPs into write strobes and completion requests.
// Optional BAR filter compiled in with `define TRN_RX_BAR_FILTER_EN.
module fofb_trn_rx_req_decoder #(
    parameter int ADDR_W  = 10,
    parameter int BAR_SEL = 0
) (
    input  logic              trn_clk,
    input  logic              trn_reset_n,
    input  logic [63:0]       trn_rd,
    input  logic [7:0]        trn_rrem_n,
    input  logic              trn_rsof_n,
    input  logic              trn_reof_n,
    input  logic              trn_rsrc_rdy_n,
    input  logic              trn_rsrc_dsc_n,
    output logic              trn_rdst_rdy_n,
    input  logic [6:0]        trn_rbar_hit_n,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic [3:0]        wr_be_o,
    output logic              req_compl_o,
    input  logic              compl_done_i,
    output logic [2:0]        req_tc_o,
    output logic              req_td_o,
    output logic              req_ep_o,
    output logic [1:0]        req_attr_o,
    output logic [9:0]        req_len_o,
    output logic [15:0]       req_rid_o,
    output logic [7:0]        req_tag_o,
    output logic [7:0]        req_be_o,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic [15:0]       drop_cnt_o
);
    typedef enum logic [2:0] {
        IDLE, MWR32_DW2, MWR64_DW3, MWR64_DATA, MRD32_DW2, MRD64_DW3, WAIT_CPL, DISCARD
    } state_t;

    state_t state, state_n, hdr_state;
    logic acc, sof, eof, dsc, bar_miss, hdr_bad, is_rd;
    logic wr_cap, rd_cap, hdr_cap, addr_cap, compl_clr;
    logic [1:0] drop;
    logic [16:0] drop_sum;
    logic [3:0] fbe_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0] wd;
    logic unused;

    assign acc = ~trn_rsrc_rdy_n & ~trn_rdst_rdy_n;
    assign sof = acc & ~trn_rsof_n;
    assign eof = acc & ~trn_reof_n;
    assign dsc = ~trn_rsrc_dsc_n;
    assign is_rd = state == MRD32_DW2 || state == MRD64_DW3;
    assign unused = ^{trn_rrem_n, trn_rbar_hit_n, trn_rd};

`ifdef TRN_RX_BAR_FILTER_EN
    assign bar_miss = trn_rbar_hit_n[BAR_SEL];
`else
    localparam int unused_bar_sel = BAR_SEL;
    assign bar_miss = 1'b0;
`endif

    // A header beat that is also EOF can never be a valid single-DW request.
    assign hdr_bad = eof || bar_miss || trn_rd[60:56] != 5'd0 || trn_rd[41:32] != 10'd1
                     || (trn_rd[62] && trn_rd[46]);
    assign hdr_state = hdr_bad ? (eof ? IDLE : DISCARD)
                     : trn_rd[62] ? (trn_rd[61] ? MWR64_DW3 : MWR32_DW2)
                     : (trn_rd[61] ? MRD64_DW3 : MRD32_DW2);

    always_comb begin
        state_n   = state;
        drop      = 2'd0;
        wr_cap    = 1'b0;
        rd_cap    = 1'b0;
        hdr_cap   = 1'b0;
        addr_cap  = 1'b0;
        compl_clr = 1'b0;
        case (state)
            IDLE: if (sof) begin
                state_n = hdr_state;
                drop    = {1'b0, hdr_bad};
                hdr_cap = 1'b1;
            end
            WAIT_CPL: if (compl_done_i) begin
                state_n   = IDLE;
                compl_clr = 1'b1;
            end
            default: if (dsc) begin
                state_n = IDLE;
                drop    = {1'b0, state != DISCARD};
            end else if (sof) begin
                // Unexpected SOF: abort the current TLP, then decode the new header.
                state_n = hdr_state;
                hdr_cap = 1'b1;
                drop    = {1'b0, state != DISCARD} + {1'b0, hdr_bad};
            end else if (acc) begin
                if (state == DISCARD) begin
                    state_n = eof ? IDLE : DISCARD;
                end else if (state == MWR64_DW3) begin
                    state_n  = eof ? IDLE : MWR64_DATA;
                    addr_cap = ~eof;
                    drop     = {1'b0, eof};
                end else begin
                    state_n = eof ? (is_rd ? WAIT_CPL : IDLE) : DISCARD;
                    wr_cap  = eof & ~is_rd;
                    rd_cap  = eof & is_rd;
                    drop    = {1'b0, ~eof};
                end
            end
        endcase
    end

    assign drop_sum = {1'b0, drop_cnt_o} + {15'd0, drop};
    assign wd = state == MWR32_DW2 ? trn_rd[31:0] : trn_rd[63:32];

    always_ff @(posedge trn_clk) begin
        if (!trn_reset_n) begin
            state          <= IDLE;
            trn_rdst_rdy_n <= 1'b1;
            wr_en_o        <= 1'b0;
            wr_addr_o      <= '0;
            wr_data_o      <= '0;
            wr_be_o        <= '0;
            req_compl_o    <= 1'b0;
            req_tc_o       <= '0;
            req_td_o       <= 1'b0;
            req_ep_o       <= 1'b0;
            req_attr_o     <= '0;
            req_len_o      <= '0;
            req_rid_o      <= '0;
            req_tag_o      <= '0;
            req_be_o       <= '0;
            req_addr_o     <= '0;
            drop_cnt_o     <= '0;
            fbe_q          <= '0;
            addr_q         <= '0;
        end else begin
            state          <= state_n;
            trn_rdst_rdy_n <= state_n == WAIT_CPL;
            wr_en_o        <= wr_cap && fbe_q != 4'd0;
            req_compl_o    <= rd_cap | (req_compl_o & ~compl_clr);
            drop_cnt_o     <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (hdr_cap) begin
                fbe_q <= trn_rd[3:0];
                if (!trn_rd[62]) begin
                    req_tc_o   <= trn_rd[54:52];
                    req_td_o   <= trn_rd[47];
                    req_ep_o   <= trn_rd[46];
                    req_attr_o <= trn_rd[45:44];
                    req_len_o  <= trn_rd[41:32];
                    req_rid_o  <= trn_rd[31:16];
                    req_tag_o  <= trn_rd[15:8];
                    req_be_o   <= trn_rd[7:0];
                end
            end
            if (addr_cap)
                addr_q <= trn_rd[ADDR_W+1:2];
            if (wr_cap) begin
                wr_addr_o <= state == MWR32_DW2 ? trn_rd[ADDR_W+33:34] : addr_q;
                wr_data_o <= {wd[7:0], wd[15:8], wd[23:16], wd[31:24]};
                wr_be_o   <= fbe_q;
            end
            if (rd_cap)
                req_addr_o <= state == MRD32_DW2 ? trn_rd[ADDR_W+33:34] : trn_rd[ADDR_W+1:2];
        end
    end
endmodule

// File: tb/tb_fofb_trn_rx_req_decoder.sv
// tb_fofb_trn_rx_req_decoder: directed and randomized checks of the TRN RX request decoder against a TLP-level model.
module tb_fofb_trn_rx_req_decoder;
    localparam int AW = 10;

    logic          trn_clk = 1'b0;
    logic          trn_reset_n = 1'b0;
    logic [63:0]   trn_rd = '0;
    logic [7:0]    trn_rrem_n = '0;
    logic          trn_rsof_n = 1'b1, trn_reof_n = 1'b1, trn_rsrc_rdy_n = 1'b1, trn_rsrc_dsc_n = 1'b1;
    logic          trn_rdst_rdy_n;
    logic [6:0]    trn_rbar_hit_n = 7'h7E;
    logic          wr_en_o, req_compl_o, req_td_o, req_ep_o;
    logic          compl_done_i = 1'b0;
    logic [AW-1:0] wr_addr_o, req_addr_o;
    logic [31:0]   wr_data_o;
    logic [3:0]    wr_be_o;
    logic [2:0]    req_tc_o;
    logic [1:0]    req_attr_o;
    logic [9:0]    req_len_o;
    logic [15:0]   req_rid_o, drop_cnt_o;
    logic [7:0]    req_tag_o, req_be_o;

    int n_chk = 0, n_fail = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    be;
    } wr_t;
    wr_t got_q[$];

    fofb_trn_rx_req_decoder #(.ADDR_W(AW), .BAR_SEL(0)) dut (
        .trn_clk(trn_clk), .trn_reset_n(trn_reset_n), .trn_rd(trn_rd), .trn_rrem_n(trn_rrem_n),
        .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n), .trn_rsrc_rdy_n(trn_rsrc_rdy_n),
        .trn_rsrc_dsc_n(trn_rsrc_dsc_n), .trn_rdst_rdy_n(trn_rdst_rdy_n), .trn_rbar_hit_n(trn_rbar_hit_n),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_be_o(wr_be_o),
        .req_compl_o(req_compl_o), .compl_done_i(compl_done_i), .req_tc_o(req_tc_o), .req_td_o(req_td_o),
        .req_ep_o(req_ep_o), .req_attr_o(req_attr_o), .req_len_o(req_len_o), .req_rid_o(req_rid_o),
        .req_tag_o(req_tag_o), .req_be_o(req_be_o), .req_addr_o(req_addr_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 trn_clk = ~trn_clk;

    always @(negedge trn_clk)
        if (trn_reset_n && wr_en_o)
            got_q.push_back(wr_t'({wr_addr_o, wr_data_o, wr_be_o}));

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] hdr(input logic [1:0] fmt, input logic [4:0] typ, input logic [2:0] tc,
                                        input logic td, input logic ep, input logic [1:0] attr,
                                        input logic [9:0] len, input logic [15:0] rid, input logic [7:0] tag,
                                        input logic [7:0] be);
        logic [63:0] h = 64'h0;
        h[62:61] = fmt; h[60:56] = typ; h[54:52] = tc; h[47] = td; h[46] = ep;
        h[45:44] = attr; h[41:32] = len; h[31:16] = rid; h[15:8] = tag; h[7:0] = be;
        return h;
    endfunction

    function automatic logic [31:0] sw(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    task automatic do_reset();
        trn_reset_n = 1'b0; trn_rsrc_rdy_n = 1'b1; trn_rsrc_dsc_n = 1'b1; compl_done_i = 1'b0;
        repeat (3) @(negedge trn_clk);
        trn_reset_n = 1'b1;
        @(negedge trn_clk);
        got_q.delete();
    endtask

    task automatic beat(input logic [63:0] d, input logic s, input logic e, input logic [7:0] rem, input logic dsc);
        int n = 0;
        @(negedge trn_clk);
        trn_rd = d; trn_rsof_n = ~s; trn_reof_n = ~e; trn_rrem_n = rem;
        trn_rsrc_rdy_n = 1'b0; trn_rsrc_dsc_n = ~dsc;
        while (trn_rdst_rdy_n && n < 64) begin
            @(negedge trn_clk);
            n++;
        end
        if (n == 64) begin
            n_chk++; n_fail++;
            $display("FAIL beat_accept: trn_rdst_rdy_n=1 after 64 cycles, required 0");
        end
        @(posedge trn_clk);
    endtask

    task automatic idle();
        @(negedge trn_clk);
        trn_rsrc_rdy_n = 1'b1; trn_rsof_n = 1'b1; trn_reof_n = 1'b1; trn_rsrc_dsc_n = 1'b1;
    endtask

    task automatic mwr32(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        beat(hdr(2'b10, 5'd0, 3'd0, 1'b0, 1'b0, 2'd0, 10'd1, 16'h0, 8'h0, {4'h0, be}), 1'b1, 1'b0, 8'h00, 1'b0);
        beat({addr, data}, 1'b0, 1'b1, 8'h00, 1'b0);
    endtask

    task automatic chk_writes(input string name, input int exp_n, input wr_t exp_w);
        n_chk++;
        if (got_q.size() !== exp_n) begin
            n_fail++;
            $display("FAIL %s_count: got %0d writes, required %0d", name, got_q.size(), exp_n);
        end
        if (exp_n == 1) begin
            n_chk++;
            if (got_q.size() < 1 || got_q[0] !== exp_w) begin
                n_fail++;
                $display("FAIL %s_data: got %h, required %h", name, got_q.size() > 0 ? got_q[0] : '0, exp_w);
            end
        end
    endtask

    task automatic chk_drop(input string name, input logic [15:0] exp);
        n_chk++;
        if (drop_cnt_o !== exp) begin
            n_fail++;
            $display("FAIL %s_drop: got %0d, required %0d", name, drop_cnt_o, exp);
        end
    endtask

    task automatic test_reset();
        trn_reset_n = 1'b0;
        repeat (3) @(negedge trn_clk);
        n_chk++;
        if ({trn_rdst_rdy_n, wr_en_o, req_compl_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_ctrl: rdst/wr_en/compl=%b, required 100", {trn_rdst_rdy_n, wr_en_o, req_compl_o});
        end
        n_chk++;
        if ({wr_addr_o, wr_data_o, wr_be_o, req_tc_o, req_td_o, req_ep_o, req_attr_o, req_len_o,
             req_rid_o, req_tag_o, req_be_o, req_addr_o, drop_cnt_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_fields: data/field outputs nonzero, required all 0");
        end
        trn_reset_n = 1'b1;
        @(negedge trn_clk);
        n_chk++;
        if (trn_rdst_rdy_n !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_rdy: trn_rdst_rdy_n=%b, required 0", trn_rdst_rdy_n);
        end
    endtask

    task automatic test_mwr32();
        do_reset();
        mwr32(32'h0000_0010, 32'h1122_3344, 4'hF);
        idle();
        repeat (3) @(negedge trn_clk);
        chk_writes("mwr32", 1, '{a: 10'd4, d: 32'h4433_2211, be: 4'hF});
        chk_drop("mwr32", 16'd0);
    endtask

    task automatic test_mwr64();
        do_reset();
        beat(hdr(2'b11, 5'd0, 3'd0, 1'b0, 1'b0, 2'd0, 10'd1, 16'h0, 8'h0, 8'h0F), 1'b1, 1'b0, 8'h00, 1'b0);
        beat({32'h0000_0001, 32'h0000_0FFC}, 1'b0, 1'b0, 8'h00, 1'b0);
        beat({32'hA5A5_5A5A, 32'h0}, 1'b0, 1'b1, 8'h0F, 1'b0);
        idle();
        n_chk++;
        if (wr_en_o !== 1'b1 || wr_addr_o !== 10'h3FF) begin
            n_fail++;
            $display("FAIL mwr64_pulse: wr_en=%b addr=%h, required 1 3ff", wr_en_o, wr_addr_o);
        end
        @(negedge trn_clk);
        n_chk++;
        if (wr_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mwr64_single: wr_en=%b a cycle later, required 0", wr_en_o);
        end
        repeat (3) @(negedge trn_clk);
        chk_writes("mwr64", 1, '{a: 10'h3FF, d: 32'h5A5A_A5A5, be: 4'hF});
    endtask

    task automatic test_mrd32();
        do_reset();
        beat(hdr(2'b00, 5'd0, 3'd0, 1'b0, 1'b0, 2'd0, 10'd1, 16'h0100, 8'h2A, 8'h0F), 1'b1, 1'b0, 8'h00, 1'b0);
        beat({32'h0000_0008, 32'h0}, 1'b0, 1'b1, 8'h00, 1'b0);
        idle();
        n_chk++;
        if ({req_compl_o, req_tag_o, req_rid_o, req_addr_o} !== {1'b1, 8'h2A, 16'h0100, 10'd2}) begin
            n_fail++;
            $display("FAIL mrd32_req: compl=%b tag=%h rid=%h addr=%h, required 1 2a 0100 002",
                     req_compl_o, req_tag_o, req_rid_o, req_addr_o);
        end
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (trn_rdst_rdy_n !== 1'b1 || req_compl_o !== 1'b1) begin
                n_fail++;
                $display("FAIL mrd32_wait%0d: rdst=%b compl=%b, required 1 1", i, trn_rdst_rdy_n, req_compl_o);
            end
            if (i < 4) @(negedge trn_clk);
        end
        compl_done_i = 1'b1;
        @(negedge trn_clk);
        compl_done_i = 1'b0;
        n_chk++;
        if (trn_rdst_rdy_n !== 1'b0 || req_compl_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mrd32_done: rdst=%b compl=%b, required 0 0", trn_rdst_rdy_n, req_compl_o);
        end
    endtask

    task automatic test_discard();
        do_reset();
        beat(hdr(2'b10, 5'd0, 3'd0, 1'b0, 1'b0, 2'd0, 10'd4, 16'h0, 8'h0, 8'h0F), 1'b1, 1'b0, 8'h00, 1'b0);
        beat({32'h10, 32'h1}, 1'b0, 1'b0, 8'h00, 1'b0);
        beat(64'h2, 1'b0, 1'b0, 8'h00, 1'b0);
        beat(64'h3, 1'b0, 1'b1, 8'h00, 1'b0);
        beat(hdr(2'b10, 5'b00010, 3'd0, 1'b0, 1'b0, 2'd0, 10'd1, 16'h0, 8'h0, 8'h0F), 1'b1, 1'b0, 8'h00, 1'b0);
        beat({32'h10, 32'h5}, 1'b0, 1'b1, 8'h00, 1'b0);
        idle();
        repeat (2) @(negedge trn_clk);
        chk_writes("discard", 0, '0);
        chk_drop("discard", 16'd2);
        got_q.delete();
        mwr32(32'h0000_0020, 32'hDEAD_BEEF, 4'hF);
        idle();
        repeat (3) @(negedge trn_clk);
        chk_writes("after_discard", 1, '{a: 10'd8, d: 32'hEFBE_ADDE, be: 4'hF});
        chk_drop("after_discard", 16'd2);
    endtask

    task automatic test_dsc();
        do_reset();
        beat(hdr(2'b10, 5'd0, 3'd0, 1'b0, 1'b0, 2'd0, 10'd1, 16'h0, 8'h0, 8'h0F), 1'b1, 1'b0, 8'h00, 1'b0);
        beat({32'h0000_0030, 32'h1234_5678}, 1'b0, 1'b1, 8'h00, 1'b1);
        idle();
        repeat (3) @(negedge trn_clk);
        chk_writes("dsc", 0, '0);
        chk_drop("dsc", 16'd1);
        mwr32(32'h0000_0034, 32'h0102_0304, 4'h5);
        idle();
        repeat (3) @(negedge trn_clk);
        chk_writes("after_dsc", 1, '{a: 10'd13, d: 32'h0403_0201, be: 4'h5});
    endtask

    task automatic test_sof_abort();
        do_reset();
        beat(hdr(2'b10, 5'd0, 3'd0, 1'b0, 1'b0, 2'd0, 10'd1, 16'h0, 8'h0, 8'h0F), 1'b1, 1'b0, 8'h00, 1'b0);
        mwr32(32'h0000_0040, 32'hCAFE_F00D, 4'h3);
        idle();
        repeat (3) @(negedge trn_clk);
        chk_writes("sof_abort", 1, '{a: 10'h10, d: 32'h0DF0_FECA, be: 4'h3});
        chk_drop("sof_abort", 16'd1);
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        beat(hdr(2'b00, 5'd0, 3'd0, 1'b0, 1'b0, 2'd0, 10'd1, 16'h0200, 8'h11, 8'h0F), 1'b1, 1'b0, 8'h00, 1'b0);
        beat({32'h0000_0004, 32'h0}, 1'b0, 1'b1, 8'h00, 1'b0);
        idle();
        trn_reset_n = 1'b0;
        @(negedge trn_clk);
        n_chk++;
        if (req_compl_o !== 1'b0 || trn_rdst_rdy_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wait: compl=%b rdst=%b, required 0 1", req_compl_o, trn_rdst_rdy_n);
        end
        trn_reset_n = 1'b1;
        @(negedge trn_clk);
        n_chk++;
        if (req_compl_o !== 1'b0 || trn_rdst_rdy_n !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wait_release: compl=%b rdst=%b, required 0 0", req_compl_o, trn_rdst_rdy_n);
        end
    endtask

    task automatic test_random();
        wr_t exp_q[$];
        int exp_drop = 0;
        do_reset();
        for (int t = 0; t < 60; t++) begin
            int kind = $urandom_range(0, 7);
            logic [1:0] fmt = 2'($urandom_range(0, 3));
            logic [4:0] typ = 5'd0;
            logic [9:0] len = 10'd1;
            logic [3:0] fbe = 4'($urandom_range(1, 15));
            logic [3:0] lbe = 4'($urandom_range(0, 15));
            logic [2:0] tc = 3'($urandom_range(0, 7));
            logic td = 1'($urandom_range(0, 1));
            logic [1:0] attr = 2'($urandom_range(0, 3));
            logic [15:0] rid = 16'($urandom);
            logic [7:0] tag = 8'($urandom);
            logic [31:0] addr = $urandom, addr_hi = $urandom, data = $urandom;
            logic ep = fmt[1] ? 1'b0 : 1'($urandom_range(0, 1));
            logic good;
            if (kind == 4) fbe = 4'd0;
            if (kind == 5) typ = 5'($urandom_range(1, 31));
            if (kind == 6) len = 10'($urandom_range(2, 1023));
            if (kind == 7) ep = 1'b1;
            good = typ == 5'd0 && len == 10'd1 && !(fmt[1] && ep);
            if (!good) exp_drop++;
            if (good && fmt[1] && fbe != 4'd0)
                exp_q.push_back('{a: addr[AW+1:2], d: sw(data), be: fbe});
            beat(hdr(fmt, typ, tc, td, ep, attr, len, rid, tag, {lbe, fbe}), 1'b1, 1'b0, 8'h00, 1'b0);
            case (fmt)
                2'b00: beat({addr, 32'($urandom)}, 1'b0, 1'b1, 8'h00, 1'b0);
                2'b01: beat({addr_hi, addr}, 1'b0, 1'b1, 8'h00, 1'b0);
                2'b10: beat({addr, data}, 1'b0, 1'b1, 8'h00, 1'b0);
                default: begin
                    beat({addr_hi, addr}, 1'b0, 1'b0, 8'h00, 1'b0);
                    beat({data, 32'h0}, 1'b0, 1'b1, 8'h0F, 1'b0);
                end
            endcase
            if (!fmt[1]) begin
                idle();
                n_chk++;
                if ({req_compl_o, trn_rdst_rdy_n} !== {good, good}) begin
                    n_fail++;
                    $display("FAIL rand_rd%0d_req: compl/rdst=%b%b, required %b%b",
                             t, req_compl_o, trn_rdst_rdy_n, good, good);
                end
                if (good) begin
                    n_chk++;
                    if ({req_tc_o, req_td_o, req_ep_o, req_attr_o, req_len_o, req_rid_o, req_tag_o, req_be_o, req_addr_o}
                        !== {tc, td, ep, attr, 10'd1, rid, tag, lbe, fbe, addr[AW+1:2]}) begin
                        n_fail++;
                        $display("FAIL rand_rd%0d_fields: tag=%h rid=%h addr=%h, required %h %h %h",
                                 t, req_tag_o, req_rid_o, req_addr_o, tag, rid, addr[AW+1:2]);
                    end
                    repeat ($urandom_range(0, 4)) @(negedge trn_clk);
                    compl_done_i = 1'b1;
                    @(negedge trn_clk);
                    compl_done_i = 1'b0;
                    n_chk++;
                    if ({req_compl_o, trn_rdst_rdy_n} !== 2'b00) begin
                        n_fail++;
                        $display("FAIL rand_rd%0d_done: compl/rdst=%b%b, required 00", t, req_compl_o, trn_rdst_rdy_n);
                    end
                end
            end else if ($urandom_range(0, 1) == 1) begin
                idle();
                repeat ($urandom_range(0, 2)) @(negedge trn_clk);
            end
        end
        idle();
        repeat (4) @(negedge trn_clk);
        n_chk++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_wr_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_chk++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_wr%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        chk_drop("rand", 16'(exp_drop));
    endtask

`ifdef TRN_RX_BAR_FILTER_EN
    task automatic test_bar_filter();
        do_reset();
        trn_rbar_hit_n = 7'h7D;
        mwr32(32'h0000_0050, 32'h5566_7788, 4'hF);
        idle();
        repeat (3) @(negedge trn_clk);
        chk_writes("bar_miss", 0, '0);
        chk_drop("bar_miss", 16'd1);
        trn_rbar_hit_n = 7'h7E;
        mwr32(32'h0000_0050, 32'h5566_7788, 4'hF);
        idle();
        repeat (3) @(negedge trn_clk);
        chk_writes("bar_hit", 1, '{a: 10'h14, d: 32'h8877_6655, be: 4'hF});
        chk_drop("bar_hit", 16'd1);
    endtask
`endif

    initial begin
        test_reset();
        test_mwr32();
        test_mwr64();
        test_mrd32();
        test_discard();
        test_dsc();
        test_sof_abort();
        test_reset_in_wait();
        test_random();
`ifdef TRN_RX_BAR_FILTER_EN
        test_bar_filter();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
